// File: rtl/sn_wr_egress_buf.sv
// Write-side egress buffer between NoC AW/W egress (no backpressure) and the SN write port.
// AW and W are absorbed in FIFOs, W framing is policed, and a W burst is held back until its AW has gone out.
module sn_wr_egress_buf #(
  parameter int AW_DEPTH = 4,
  parameter int W_DEPTH  = 16,
  parameter int PEND_MAX = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        aw_valid,
  input  logic [81:0]                 aw_payload,
  input  logic [1:0]                  aw_srcid,
  input  logic                        w_valid,
  input  logic                        w_head,
  input  logic                        w_tail,
  input  logic [81:0]                 w_payload,
  input  logic [1:0]                  w_srcid,
  output logic                        m_aw_valid,
  input  logic                        m_aw_ready,
  output logic [81:0]                 m_aw_payload,
  output logic [1:0]                  m_aw_srcid,
  output logic                        m_w_valid,
  input  logic                        m_w_ready,
  output logic [81:0]                 m_w_payload,
  output logic                        m_w_last,
  output logic [1:0]                  m_w_srcid,
  output logic [$clog2(AW_DEPTH):0]   aw_level,
  output logic [$clog2(W_DEPTH):0]    w_level,
  output logic                        aw_ovf,
  output logic                        w_ovf,
  output logic                        frm_err
);

  localparam int AWA = $clog2(AW_DEPTH);
  localparam int WA  = $clog2(W_DEPTH);
  localparam int PW  = $clog2(PEND_MAX + 1);

  typedef enum logic {IDLE, BURST} frm_state_t;

  logic [83:0]    aw_mem [AW_DEPTH];
  logic [AWA-1:0] aw_wr_ptr, aw_rd_ptr;
  logic           aw_full, aw_empty, aw_push, aw_pop;

  logic [84:0]    w_mem [W_DEPTH];
  logic [WA-1:0]  w_wr_ptr, w_rd_ptr;
  logic           w_full, w_empty, w_push, w_pop;

  logic [PW-1:0]  pend_aw;
  logic           w_last_hs;

  frm_state_t     frm_state, frm_next;
  logic [1:0]     burst_srcid;
  logic           w_store, frm_set;

  assign aw_full  = (aw_level == (AWA+1)'(AW_DEPTH));
  assign aw_empty = (aw_level == '0);
  assign aw_push  = aw_valid && !aw_full;
  assign aw_pop   = m_aw_valid && m_aw_ready;

  assign w_full   = (w_level == (WA+1)'(W_DEPTH));
  assign w_empty  = (w_level == '0);
  assign w_push   = w_store && !w_full;
  assign w_pop    = m_w_valid && m_w_ready;
  assign w_last_hs = w_pop && m_w_last;

  // Issue limits: AW stops at PEND_MAX outstanding bursts, W waits for at least one issued AW.
  assign m_aw_valid = !aw_empty && (pend_aw < PW'(PEND_MAX));
  assign m_w_valid  = !w_empty && (pend_aw != '0);

  assign {m_aw_srcid, m_aw_payload}          = m_aw_valid ? aw_mem[aw_rd_ptr] : '0;
  assign {m_w_srcid, m_w_last, m_w_payload}  = m_w_valid  ? w_mem[w_rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (aw_push) aw_mem[aw_wr_ptr] <= {aw_srcid, aw_payload};
    if (w_push)  w_mem[w_wr_ptr]   <= {w_srcid, w_tail, w_payload};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_wr_ptr <= '0;
      aw_rd_ptr <= '0;
      aw_level  <= '0;
      aw_ovf    <= 1'b0;
    end else begin
      if (aw_push) aw_wr_ptr <= aw_wr_ptr + AWA'(1);
      if (aw_pop)  aw_rd_ptr <= aw_rd_ptr + AWA'(1);
      if (aw_valid && aw_full) aw_ovf <= 1'b1;
      unique case ({aw_push, aw_pop})
        2'b10:   aw_level <= aw_level + (AWA+1)'(1);
        2'b01:   aw_level <= aw_level - (AWA+1)'(1);
        default: aw_level <= aw_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_wr_ptr <= '0;
      w_rd_ptr <= '0;
      w_level  <= '0;
      w_ovf    <= 1'b0;
    end else begin
      if (w_push) w_wr_ptr <= w_wr_ptr + WA'(1);
      if (w_pop)  w_rd_ptr <= w_rd_ptr + WA'(1);
      if (w_store && w_full) w_ovf <= 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   w_level <= w_level + (WA+1)'(1);
        2'b01:   w_level <= w_level - (WA+1)'(1);
        default: w_level <= w_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_aw <= '0;
    end else begin
      unique case ({aw_pop, w_last_hs})
        2'b10:   pend_aw <= pend_aw + PW'(1);
        2'b01:   pend_aw <= pend_aw - PW'(1);
        default: pend_aw <= pend_aw;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_state   <= IDLE;
      burst_srcid <= '0;
      frm_err     <= 1'b0;
    end else begin
      frm_state <= frm_next;
      if (w_valid && frm_state == IDLE && w_head) burst_srcid <= w_srcid;
      if (frm_set) frm_err <= 1'b1;
    end
  end

  // Framing walks on every beat, including ones later dropped for overflow.
  always_comb begin
    frm_next = frm_state;
    w_store  = 1'b0;
    frm_set  = 1'b0;
    if (w_valid) begin
      unique case (frm_state)
        IDLE: begin
          if (w_head) begin
            w_store = 1'b1;
            if (!w_tail) frm_next = BURST;
          end else begin
            frm_set = 1'b1;
          end
        end
        BURST: begin
          w_store = 1'b1;
          if (w_head || (w_srcid != burst_srcid)) frm_set = 1'b1;
          if (w_tail) frm_next = IDLE;
        end
        default: frm_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sn_wr_egress_buf.sv
// Directed bench for sn_wr_egress_buf: a per-cycle vector table for the basic flows,
// then hand sequences for overflow, framing, pend limit and asynchronous reset.
module tb_sn_wr_egress_buf;

  logic        clk;
  logic        rst;
  logic        aw_valid;
  logic [81:0] aw_payload;
  logic [1:0]  aw_srcid;
  logic        w_valid, w_head, w_tail;
  logic [81:0] w_payload;
  logic [1:0]  w_srcid;
  logic        m_aw_valid, m_aw_ready;
  logic [81:0] m_aw_payload;
  logic [1:0]  m_aw_srcid;
  logic        m_w_valid, m_w_ready;
  logic [81:0] m_w_payload;
  logic        m_w_last;
  logic [1:0]  m_w_srcid;
  logic [3:0]  aw_level;
  logic [4:0]  w_level;
  logic        aw_ovf, w_ovf, frm_err;

  int pass_count  = 0;
  int check_count = 0;

  sn_wr_egress_buf #(.AW_DEPTH(8), .W_DEPTH(16), .PEND_MAX(7)) dut (
    .clk(clk), .rst(rst),
    .aw_valid(aw_valid), .aw_payload(aw_payload), .aw_srcid(aw_srcid),
    .w_valid(w_valid), .w_head(w_head), .w_tail(w_tail),
    .w_payload(w_payload), .w_srcid(w_srcid),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_aw_payload(m_aw_payload), .m_aw_srcid(m_aw_srcid),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_w_payload(m_w_payload), .m_w_last(m_w_last), .m_w_srcid(m_w_srcid),
    .aw_level(aw_level), .w_level(w_level),
    .aw_ovf(aw_ovf), .w_ovf(w_ovf), .frm_err(frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        aw_v;
    logic [81:0] aw_pl;
    logic [1:0]  aw_sid;
    logic        w_v, head, tail;
    logic [81:0] w_pl;
    logic [1:0]  w_sid;
    logic        aw_rdy, w_rdy;
    logic        x_aw_v;
    logic [81:0] x_aw_pl;
    logic [1:0]  x_aw_sid;
    logic        x_w_v;
    logic [81:0] x_w_pl;
    logic        x_w_last;
    logic [1:0]  x_w_sid;
    logic [3:0]  x_aw_lvl;
    logic [4:0]  x_w_lvl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic aw_v, input logic [81:0] aw_pl, input logic [1:0] aw_sid,
    input logic w_v, input logic head, input logic tail,
    input logic [81:0] w_pl, input logic [1:0] w_sid,
    input logic x_aw_v, input logic [81:0] x_aw_pl, input logic [1:0] x_aw_sid,
    input logic x_w_v, input logic [81:0] x_w_pl, input logic x_w_last,
    input logic [1:0] x_w_sid, input logic [3:0] x_aw_lvl, input logic [4:0] x_w_lvl);
    vec_t v;
    v.aw_v = aw_v; v.aw_pl = aw_pl; v.aw_sid = aw_sid;
    v.w_v = w_v; v.head = head; v.tail = tail; v.w_pl = w_pl; v.w_sid = w_sid;
    v.aw_rdy = 1'b1; v.w_rdy = 1'b1;
    v.x_aw_v = x_aw_v; v.x_aw_pl = x_aw_pl; v.x_aw_sid = x_aw_sid;
    v.x_w_v = x_w_v; v.x_w_pl = x_w_pl; v.x_w_last = x_w_last; v.x_w_sid = x_w_sid;
    v.x_aw_lvl = x_aw_lvl; v.x_w_lvl = x_w_lvl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [81:0] actual, input logic [81:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    aw_valid = v.aw_v; aw_payload = v.aw_pl; aw_srcid = v.aw_sid;
    w_valid = v.w_v; w_head = v.head; w_tail = v.tail;
    w_payload = v.w_pl; w_srcid = v.w_sid;
    m_aw_ready = v.aw_rdy; m_w_ready = v.w_rdy;
  endtask

  task automatic clearInputs();
    aw_valid = 1'b0; aw_payload = '0; aw_srcid = '0;
    w_valid = 1'b0; w_head = 1'b0; w_tail = 1'b0; w_payload = '0; w_srcid = '0;
  endtask

  task automatic doReset();
    clearInputs();
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic driveBeat(input logic head, input logic tail, input logic [81:0] pl, input logic [1:0] sid);
    w_valid = 1'b1; w_head = head; w_tail = tail; w_payload = pl; w_srcid = sid;
  endtask

  initial begin
    int hs;
    int got;
    logic [81:0] beat_pl [4];
    logic        beat_last [4];
    logic [1:0]  beat_sid [4];
    logic        aw_seen;

    rst = 1'b1;
    clearInputs();
    m_aw_ready = 1'b1; m_w_ready = 1'b1;

    // Single write (payload 0x1, srcid 2) followed by W-before-AW (srcid 1, AW 5 cycles late).
    vecs.push_back(mk(1, 'h1, 2, 1, 1, 0, 'h10, 2,  0, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 0, 'h11, 2,  1, 'h1, 2, 0, 0,   0, 0, 1, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 0, 'h12, 2,  0, 0, 0, 1, 'h10,  0, 2, 0, 2));
    vecs.push_back(mk(0, 0,   0, 1, 0, 1, 'h13, 2,  0, 0, 0, 1, 'h11,  0, 2, 0, 2));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,    0,  0, 0, 0, 1, 'h12,  0, 2, 0, 2));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,    0,  0, 0, 0, 1, 'h13,  1, 2, 0, 1));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,    0,  0, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 1, 0, 'h20, 1,  0, 0, 0, 0, 0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 0, 'h21, 1,  0, 0, 0, 0, 0,     0, 0, 0, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, 0, 'h22, 1,  0, 0, 0, 0, 0,     0, 0, 0, 2));
    vecs.push_back(mk(0, 0,   0, 1, 0, 1, 'h23, 1,  0, 0, 0, 0, 0,     0, 0, 0, 3));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,    0,  0, 0, 0, 0, 0,     0, 0, 0, 4));
    vecs.push_back(mk(1, 'h5, 1, 0, 0, 0, 0,    0,  0, 0, 0, 0, 0,     0, 0, 0, 4));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,    0,  1, 'h5, 1, 0, 0,   0, 0, 1, 4));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,    0,  0, 0, 0, 1, 'h20,  0, 1, 0, 4));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,    0,  0, 0, 0, 1, 'h21,  0, 1, 0, 3));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,    0,  0, 0, 0, 1, 'h22,  0, 1, 0, 2));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,    0,  0, 0, 0, 1, 'h23,  1, 1, 0, 1));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0,    0,  0, 0, 0, 0, 0,     0, 0, 0, 0));

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("r%0d.aw_valid", i), 82'(m_aw_valid), 82'(vecs[i].x_aw_v));
      checkOutput($sformatf("r%0d.aw_payload", i), m_aw_payload, vecs[i].x_aw_pl);
      checkOutput($sformatf("r%0d.aw_srcid", i), 82'(m_aw_srcid), 82'(vecs[i].x_aw_sid));
      checkOutput($sformatf("r%0d.w_valid", i), 82'(m_w_valid), 82'(vecs[i].x_w_v));
      checkOutput($sformatf("r%0d.w_payload", i), m_w_payload, vecs[i].x_w_pl);
      checkOutput($sformatf("r%0d.w_last", i), 82'(m_w_last), 82'(vecs[i].x_w_last));
      checkOutput($sformatf("r%0d.w_srcid", i), 82'(m_w_srcid), 82'(vecs[i].x_w_sid));
      checkOutput($sformatf("r%0d.aw_level", i), 82'(aw_level), 82'(vecs[i].x_aw_lvl));
      checkOutput($sformatf("r%0d.w_level", i), 82'(w_level), 82'(vecs[i].x_w_lvl));
    end
    checkOutput("table.flags", 82'({aw_ovf, w_ovf, frm_err}), 82'(0));

    // Overflow: 17 beats into a 16-deep FIFO with the SN stalled.
    $display("[TB] overflow sequence");
    doReset();
    m_w_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      driveBeat(i == 0, i == 16, 82'(i), 2'd0);
      if (i == 16) begin
        #1;
        checkOutput("ovf.level_before", 82'(w_level), 82'(16));
        checkOutput("ovf.flag_before", 82'(w_ovf), 82'(0));
      end
    end
    @(negedge clk);
    clearInputs();
    aw_valid = 1'b1; aw_payload = 'h99;
    #1;
    checkOutput("ovf.level_after", 82'(w_level), 82'(16));
    checkOutput("ovf.flag_after", 82'(w_ovf), 82'(1));
    checkOutput("ovf.frm_err", 82'(frm_err), 82'(0));
    @(negedge clk);
    aw_valid = 1'b0;
    m_w_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 17; c++) begin
      @(negedge clk);
      #1;
      if (m_w_valid) begin
        checkOutput($sformatf("ovf.beat%0d", got), m_w_payload, 82'(got));
        if (m_w_last) checkOutput("ovf.unexpected_last", 82'(m_w_last), 82'(0));
        got++;
      end
      if (got == 16 && w_level == 0) break;
    end
    checkOutput("ovf.beats_out", 82'(got), 82'(16));

    // Framing: non-head beat in IDLE is dropped.
    $display("[TB] framing sequences");
    doReset();
    driveBeat(1'b0, 1'b1, 'h77, 2'd1);
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("frm.idle_err", 82'(frm_err), 82'(1));
    checkOutput("frm.idle_level", 82'(w_level), 82'(0));

    // Framing: srcid changes mid-burst, both beats kept.
    doReset();
    driveBeat(1'b1, 1'b0, 'h80, 2'd1);
    @(negedge clk);
    #1;
    checkOutput("frm.clean_head", 82'(frm_err), 82'(0));
    driveBeat(1'b0, 1'b1, 'h81, 2'd3);
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("frm.sid_err", 82'(frm_err), 82'(1));
    checkOutput("frm.sid_level", 82'(w_level), 82'(2));

    // Pend limit: 8 AWs with W stalled, only 7 may issue.
    $display("[TB] pend limit sequence");
    doReset();
    m_w_ready = 1'b0;
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      aw_valid = (c < 8);
      aw_payload = 82'(c);
      #1;
      if (m_aw_valid && m_aw_ready) hs++;
    end
    checkOutput("pend.handshakes", 82'(hs), 82'(7));
    checkOutput("pend.aw_blocked", 82'(m_aw_valid), 82'(0));
    checkOutput("pend.aw_level", 82'(aw_level), 82'(1));
    @(negedge clk);
    aw_valid = 1'b0;
    driveBeat(1'b1, 1'b1, 'hAA, 2'd0);
    m_w_ready = 1'b1;
    #1;
    checkOutput("pend.still_blocked", 82'(m_aw_valid), 82'(0));
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("pend.w_last_valid", 82'({m_w_valid, m_w_last}), 82'(3));
    checkOutput("pend.aw_held", 82'(m_aw_valid), 82'(0));
    @(negedge clk);
    #1;
    checkOutput("pend.aw_released", 82'(m_aw_valid), 82'(1));
    checkOutput("pend.aw_payload", m_aw_payload, 82'(7));

    // Reset mid-burst, then a clean burst must pass.
    $display("[TB] reset mid-burst sequence");
    doReset();
    driveBeat(1'b0, 1'b0, 'h1, 2'd0);
    @(negedge clk);
    aw_valid = 1'b1; aw_payload = 'h30; aw_srcid = 2'd3;
    driveBeat(1'b1, 1'b0, 'h40, 2'd3);
    @(negedge clk);
    aw_valid = 1'b0;
    driveBeat(1'b0, 1'b0, 'h41, 2'd3);
    @(negedge clk);
    driveBeat(1'b0, 1'b0, 'h42, 2'd3);
    #1;
    checkOutput("rst.pre_level", 82'(w_level), 82'(2));
    checkOutput("rst.pre_err", 82'(frm_err), 82'(1));
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst.levels", 82'({aw_level, w_level}), 82'(0));
    checkOutput("rst.flags", 82'({aw_ovf, w_ovf, frm_err}), 82'(0));
    checkOutput("rst.valids", 82'({m_aw_valid, m_w_valid}), 82'(0));
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
    aw_valid = 1'b1; aw_payload = 'h50; aw_srcid = 2'd0;
    driveBeat(1'b1, 1'b0, 'h60, 2'd0);
    @(negedge clk);
    aw_valid = 1'b0;
    driveBeat(1'b0, 1'b1, 'h61, 2'd0);
    #1;
    aw_seen = m_aw_valid && (m_aw_payload == 'h50);
    @(negedge clk);
    clearInputs();
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      #1;
      if (m_w_valid) begin
        beat_pl[got] = m_w_payload; beat_last[got] = m_w_last; beat_sid[got] = m_w_srcid;
        got++;
      end
      @(negedge clk);
    end
    checkOutput("post.aw_seen", 82'(aw_seen), 82'(1));
    checkOutput("post.beats", 82'(got), 82'(2));
    if (got >= 2) begin
      checkOutput("post.beat0", {beat_pl[0][79:0], beat_last[0], 1'b0}, {80'h60, 1'b0, 1'b0});
      checkOutput("post.beat1", {beat_pl[1][79:0], beat_last[1], 1'b0}, {80'h61, 1'b1, 1'b0});
      checkOutput("post.srcid", 82'({beat_sid[0], beat_sid[1]}), 82'(0));
    end
    checkOutput("post.frm_err", 82'(frm_err), 82'(0));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
